// File: rtl/troco_dispenser_ctrl_if.sv
// Request/eject/report bundle between the vending datapath, the change
// sequencer and the coin hoppers.
interface troco_dispenser_ctrl_if;
    logic        req;
    logic [7:0]  valor_troco;
    logic [23:0] moedas_carteira;
    logic        ejetar_ack;
    logic [2:0]  ejetar;
    logic        busy;
    logic        done;
    logic        erro;
    logic [23:0] moedas_troco;
    logic [7:0]  restante;

    modport master (
        output req, valor_troco, moedas_carteira, ejetar_ack,
        input  ejetar, busy, done, erro, moedas_troco, restante
    );

    modport slave (
        input  req, valor_troco, moedas_carteira, ejetar_ack,
        output ejetar, busy, done, erro, moedas_troco, restante
    );
endinterface

// File: rtl/troco_dispenser_ctrl.sv
// Change sequencer: plans a greedy R$1,00/R$0,50/R$0,25 coin mix and ejects one coin at a time.
// Optional per-coin ack timeout enabled by defining DISPENSE_TIMEOUT_EN.
module troco_dispenser_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    troco_dispenser_ctrl_if.slave bus
);
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S_IDLE     = 3'd0;
    localparam logic [SW-1:0] S_PLAN     = 3'd1;
    localparam logic [SW-1:0] S_DISPENSE = 3'd2;
    localparam logic [SW-1:0] S_GAP      = 3'd3;
    localparam logic [SW-1:0] S_DONE     = 3'd4;
    localparam logic [SW-1:0] S_ERROR    = 3'd5;

    localparam logic [2:0] EJ_100  = 3'b100;
    localparam logic [2:0] EJ_50   = 3'b010;
    localparam logic [2:0] EJ_25   = 3'b001;
    localparam logic [2:0] EJ_NONE = 3'b000;

    logic [SW-1:0] state, state_nxt;
    logic [CW-1:0] restante, restante_nxt;
    // Hold the latched inventory in IDLE/PLAN, then the remaining planned coins.
    logic [CW-1:0] cnt100, cnt100_nxt, cnt50, cnt50_nxt, cnt25, cnt25_nxt;
    logic [3*CW-1:0] moedas, moedas_nxt;
    logic [2:0]    ejetar, ejetar_nxt;
    logic          busy, busy_nxt, done, done_nxt, erro, erro_nxt;

    logic [CW-1:0] q100_c, q50_c, q25_c;
    logic [CW-1:0] p100_c, p50_c, p25_c;
    logic [CW-1:0] r1_c, r2_c, r3_c;

`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_cnt;
`else
    logic [CW-1:0] unused_tmo_c;
    assign unused_tmo_c = CW'(TIMEOUT_CYCLES);
`endif

    function automatic logic [2:0] pick_coin(input logic [CW-1:0] n100,
                                             input logic [CW-1:0] n50,
                                             input logic [CW-1:0] n25);
        if (n100 != '0)     return EJ_100;
        else if (n50 != '0) return EJ_50;
        else if (n25 != '0) return EJ_25;
        else                return EJ_NONE;
    endfunction

    // Greedy plan against the latched amount and inventory; exact for 25/50/100.
    always_comb begin
        q100_c = restante / CW'(100);
        p100_c = (q100_c < cnt100) ? q100_c : cnt100;
        r1_c   = restante - CW'(p100_c * CW'(100));
        q50_c  = r1_c / CW'(50);
        p50_c  = (q50_c < cnt50) ? q50_c : cnt50;
        r2_c   = r1_c - CW'(p50_c * CW'(50));
        q25_c  = r2_c / CW'(25);
        p25_c  = (q25_c < cnt25) ? q25_c : cnt25;
        r3_c   = r2_c - CW'(p25_c * CW'(25));
    end

    always_comb begin
        state_nxt    = state;
        restante_nxt = restante;
        cnt100_nxt   = cnt100;
        cnt50_nxt    = cnt50;
        cnt25_nxt    = cnt25;
        moedas_nxt   = moedas;

        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    restante_nxt = bus.valor_troco;
                    cnt100_nxt   = bus.moedas_carteira[23:16];
                    cnt50_nxt    = bus.moedas_carteira[15:8];
                    cnt25_nxt    = bus.moedas_carteira[7:0];
                    state_nxt    = S_PLAN;
                end
            end
            S_PLAN: begin
                moedas_nxt = '0;
                cnt100_nxt = p100_c;
                cnt50_nxt  = p50_c;
                cnt25_nxt  = p25_c;
                if (r3_c != '0)
                    state_nxt = S_ERROR;
                else if (p100_c == '0 && p50_c == '0 && p25_c == '0)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_DISPENSE;
            end
            S_DISPENSE: begin
                if (bus.ejetar_ack) begin
                    state_nxt = S_GAP;
                    case (ejetar)
                        EJ_100: begin
                            cnt100_nxt         = cnt100 - CW'(1);
                            moedas_nxt[23:16]  = moedas[23:16] + CW'(1);
                            restante_nxt       = restante - CW'(100);
                        end
                        EJ_50: begin
                            cnt50_nxt          = cnt50 - CW'(1);
                            moedas_nxt[15:8]   = moedas[15:8] + CW'(1);
                            restante_nxt       = restante - CW'(50);
                        end
                        EJ_25: begin
                            cnt25_nxt          = cnt25 - CW'(1);
                            moedas_nxt[7:0]    = moedas[7:0] + CW'(1);
                            restante_nxt       = restante - CW'(25);
                        end
                        default: ;
                    endcase
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_ERROR;
                end
`endif
            end
            S_GAP: begin
                if (cnt100 != '0 || cnt50 != '0 || cnt25 != '0)
                    state_nxt = S_DISPENSE;
                else
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ejetar_nxt = (state_nxt == S_DISPENSE) ? pick_coin(cnt100_nxt, cnt50_nxt, cnt25_nxt)
                                               : EJ_NONE;
        busy_nxt   = (state_nxt == S_PLAN) || (state_nxt == S_DISPENSE) || (state_nxt == S_GAP);
        done_nxt   = (state_nxt == S_DONE);
        erro_nxt   = (state_nxt == S_ERROR);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            restante <= '0;
            cnt100   <= '0;
            cnt50    <= '0;
            cnt25    <= '0;
            moedas   <= '0;
            ejetar   <= EJ_NONE;
            busy     <= 1'b0;
            done     <= 1'b0;
            erro     <= 1'b0;
        end else begin
            state    <= state_nxt;
            restante <= restante_nxt;
            cnt100   <= cnt100_nxt;
            cnt50    <= cnt50_nxt;
            cnt25    <= cnt25_nxt;
            moedas   <= moedas_nxt;
            ejetar   <= ejetar_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            erro     <= erro_nxt;
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    // Counts unacknowledged DISPENSE cycles; zero everywhere else so entry starts clean.
    always_ff @(posedge clock) begin
        if (!reset_n)
            tmo_cnt <= '0;
        else if (state == S_DISPENSE && !bus.ejetar_ack)
            tmo_cnt <= tmo_cnt + CW'(1);
        else
            tmo_cnt <= '0;
    end
`endif

    assign bus.ejetar       = ejetar;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.erro         = erro;
    assign bus.moedas_troco = moedas;
    assign bus.restante     = restante;
endmodule

// File: tb/tb_troco_dispenser_ctrl.sv
// Self-checking bench for troco_dispenser_ctrl: vector table with an eject scoreboard,
// plus reset-abort and (with DISPENSE_TIMEOUT_EN) ack-timeout sequences.
module tb_troco_dispenser_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    troco_dispenser_ctrl_if bus ();

    troco_dispenser_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  valor;
        logic [23:0] inv;
        logic        exp_ok;
        logic [23:0] exp_moedas;
        logic [7:0]  exp_rest;
        int          exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ejetar"}, 32'(bus.ejetar), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_done_erro"}, 32'({bus.done, bus.erro}), 32'd0);
        check({name, "_moedas"}, 32'(bus.moedas_troco), 32'd0);
        check({name, "_restante"}, 32'(bus.restante), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        bit term;
        bit after_ack;
        logic [2:0] exp_ej;
        exp_q.delete();
        if (v.exp_ok) begin
            for (int k = 0; k < int'(v.exp_moedas[23:16]); k++) exp_q.push_back(3'b100);
            for (int k = 0; k < int'(v.exp_moedas[15:8]); k++)  exp_q.push_back(3'b010);
            for (int k = 0; k < int'(v.exp_moedas[7:0]); k++)   exp_q.push_back(3'b001);
        end
        bus.valor_troco = v.valor;
        bus.moedas_carteira = v.inv;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        cyc = 1;
        term = 1'b0;
        after_ack = 1'b0;
        check($sformatf("v%0d_busy_plan", idx), 32'(bus.busy), 32'd1);
        while (!term && cyc < 200) begin
            if (after_ack) begin
                check($sformatf("v%0d_gap", idx), 32'(bus.ejetar), 32'd0);
                after_ack = 1'b0;
            end
            if (bus.ejetar != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_extra_eject", idx), 32'(bus.ejetar), 32'd0);
                end else begin
                    exp_ej = exp_q.pop_front();
                    check($sformatf("v%0d_eject", idx), 32'(bus.ejetar), 32'(exp_ej));
                end
                bus.ejetar_ack = 1'b1;
                step();
                bus.ejetar_ack = 1'b0;
                cyc++;
                after_ack = 1'b1;
            end else if (bus.done || bus.erro) begin
                term = 1'b1;
            end else begin
                step();
                cyc++;
            end
        end
        if (!term) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d_no_end: got no done/erro expected termination within 200 cycles", idx);
        end
        check($sformatf("v%0d_done", idx), 32'(bus.done), 32'(v.exp_ok));
        check($sformatf("v%0d_erro", idx), 32'(bus.erro), 32'(!v.exp_ok));
        check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
        check($sformatf("v%0d_busy_end", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d_moedas", idx), 32'(bus.moedas_troco), 32'(v.exp_moedas));
        check($sformatf("v%0d_restante", idx), 32'(bus.restante), 32'(v.exp_rest));
        check($sformatf("v%0d_queue_left", idx), 32'(exp_q.size()), 32'd0);
        step();
        check($sformatf("v%0d_pulse_end", idx), 32'({bus.done, bus.erro}), 32'd0);
        check($sformatf("v%0d_moedas_hold", idx), 32'(bus.moedas_troco), 32'(v.exp_moedas));
        check($sformatf("v%0d_restante_hold", idx), 32'(bus.restante), 32'(v.exp_rest));
    endtask

    initial begin
        int wait_cyc;
        vecs[0] = '{8'd175, 24'h020104, 1'b1, 24'h010101, 8'd0,   8};
        vecs[1] = '{8'd100, 24'h000102, 1'b1, 24'h000102, 8'd0,   8};
        vecs[2] = '{8'd30,  24'h020104, 1'b0, 24'h000000, 8'd30,  2};
        vecs[3] = '{8'd100, 24'h000101, 1'b0, 24'h000000, 8'd100, 2};
        vecs[4] = '{8'd0,   24'h020104, 1'b1, 24'h000000, 8'd0,   2};
        vecs[5] = '{8'd250, 24'h050505, 1'b1, 24'h020100, 8'd0,   8};
        vecs[6] = '{8'd25,  24'h000001, 1'b1, 24'h000001, 8'd0,   4};
        vecs[7] = '{8'd255, 24'h0A0A0A, 1'b0, 24'h000000, 8'd255, 2};
        vecs[8] = '{8'd200, 24'h010004, 1'b1, 24'h010004, 8'd0,  12};

        bus.req = 1'b0;
        bus.valor_troco = '0;
        bus.moedas_carteira = '0;
        bus.ejetar_ack = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset while the R$1,00 hopper is being commanded.
        bus.valor_troco = 8'd175;
        bus.moedas_carteira = 24'h020104;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        wait_cyc = 0;
        while (bus.ejetar != 3'b100 && wait_cyc < 10) begin
            step();
            wait_cyc++;
        end
        check("rst_reach_eject", 32'(bus.ejetar), 32'h4);
        reset_n = 1'b0;
        bus.req = 1'b1;
        bus.ejetar_ack = 1'b1;
        step();
        check_all_zero("rst_mid");
        bus.ejetar_ack = 1'b0;
        step();
        check_all_zero("rst_hold");
        bus.req = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_after_idle", 32'({bus.busy, bus.ejetar, bus.done, bus.erro}), 32'd0);
        end

`ifdef DISPENSE_TIMEOUT_EN
        // Second coin never acknowledged: abort after 8 unacked DISPENSE cycles.
        bus.valor_troco = 8'd75;
        bus.moedas_carteira = 24'h000101;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step();
        check("tmo_first_coin", 32'(bus.ejetar), 32'h2);
        bus.ejetar_ack = 1'b1;
        step();
        bus.ejetar_ack = 1'b0;
        check("tmo_gap", 32'(bus.ejetar), 32'd0);
        step();
        check("tmo_second_coin", 32'(bus.ejetar), 32'h1);
        for (int k = 0; k < 7; k++) step();
        check("tmo_still_waiting", 32'({bus.ejetar, bus.erro}), 32'h2);
        step();
        check("tmo_erro", 32'(bus.erro), 32'd1);
        check("tmo_ejetar_drop", 32'(bus.ejetar), 32'd0);
        check("tmo_moedas", 32'(bus.moedas_troco), 32'h000100);
        check("tmo_restante", 32'(bus.restante), 32'd25);
        step();
`endif

        run_vec(vecs[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
